// File: rtl/gte_pkg.sv
// Shared types and constants for the GTE matrix*vector MAC sequencer.
// Holds the state encoding, mux select codes and the per-state output decode.
package gte_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TR,
        C0,
        C1,
        C2,
        WB,
        DONE
    } gte_state_e;

    localparam logic [3:0] MAT_C0   = 4'd0;
    localparam logic [3:0] MAT_C1   = 4'd1;
    localparam logic [3:0] MAT_C2   = 4'd2;
    localparam logic [3:0] SR_VCOMP = 4'd0;
    localparam logic [3:0] SR_ZERO  = 4'd4;
    localparam logic [1:0] CV_NONE  = 2'd3;

    typedef struct packed {
        logic       multi;
        logic [1:0] mx;
        logic [1:0] vec;
        logic [1:0] cv;
    } gte_cmd_t;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [1:0] mat;
        logic [1:0] vcompo;
        logic [3:0] sel_left;
        logic [3:0] sel_right;
        logic       acc_load_tr;
        logic       acc_clr;
        logic       acc_en;
        logic       wb_en;
        logic [1:0] vec_idx;
    } gte_out_t;

    // Output image of a state; strobes here are unmasked, stall gating happens at the ports.
    function automatic gte_out_t gte_decode(input gte_state_e st, input gte_cmd_t cmd,
                                            input logic [1:0] cnt);
        gte_out_t o;
        o = '0;
        if (st != IDLE) begin
            o.busy    = 1'b1;
            o.mat     = cmd.mx;
            o.vcompo  = cmd.multi ? cnt : cmd.vec;
            o.vec_idx = cnt;
        end
        case (st)
            TR: begin
                o.acc_load_tr = 1'b1;
                o.sel_right   = SR_ZERO;
            end
            C0: begin
                o.sel_left  = MAT_C0;
                o.sel_right = SR_VCOMP;
                o.acc_en    = 1'b1;
                o.acc_clr   = (cmd.cv == CV_NONE);
            end
            C1: begin
                o.sel_left  = MAT_C1;
                o.sel_right = SR_VCOMP;
                o.acc_en    = 1'b1;
            end
            C2: begin
                o.sel_left  = MAT_C2;
                o.sel_right = SR_VCOMP;
                o.acc_en    = 1'b1;
            end
            WB:      o.wb_en = 1'b1;
            DONE:    o.done  = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/gte_mac_sequencer.sv
// Select/strobe sequencer for GTE matrix*vector commands (single vector or V0..V2).
// Outputs are registered from the next-state decode; stall masks the strobes combinationally.
module gte_mac_sequencer
    import gte_pkg::*;
#(
    parameter int NVEC_MULTI = 3
) (
    input  logic       i_clk,
    input  logic       i_nRst,
    input  logic       i_start,
    input  logic       i_multi,
    input  logic [1:0] i_mx,
    input  logic [1:0] i_vec,
    input  logic [1:0] i_cv,
    input  logic       i_stall,
    output logic       o_busy,
    output logic       o_done,
    output logic [1:0] o_mat,
    output logic [1:0] o_vcompo,
    output logic [3:0] o_selLeft,
    output logic [3:0] o_selRight,
    output logic       o_accLoadTr,
    output logic       o_accClr,
    output logic       o_accEn,
    output logic       o_wbEn,
    output logic [1:0] o_vecIdx
);

    localparam logic [1:0] LAST_VEC = 2'(NVEC_MULTI - 1);

    gte_state_e state_q, state_d;
    gte_cmd_t   cmd_q, cmd_d;
    logic [1:0] cnt_q, cnt_d;
    gte_out_t   out_q;

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            // Stall is deliberately ignored here so a start is never lost.
            if (i_start) begin
                cmd_d   = '{multi: i_multi, mx: i_mx, vec: i_vec, cv: i_cv};
                cnt_d   = '0;
                state_d = (i_cv == CV_NONE) ? C0 : TR;
            end
        end else if (!i_stall) begin
            case (state_q)
                TR: state_d = C0;
                C0: state_d = C1;
                C1: state_d = C2;
                C2: state_d = WB;
                WB: begin
                    if (cmd_q.multi && (cnt_q != LAST_VEC)) begin
                        cnt_d   = cnt_q + 2'd1;
                        state_d = (cmd_q.cv == CV_NONE) ? C0 : TR;
                    end else begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    cmd_d   = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            out_q   <= gte_decode(state_d, cmd_d, cnt_d);
        end
    end

    assign o_busy      = out_q.busy;
    assign o_done      = out_q.done & ~i_stall;
    assign o_mat       = out_q.mat;
    assign o_vcompo    = out_q.vcompo;
    assign o_selLeft   = out_q.sel_left;
    assign o_selRight  = out_q.sel_right;
    assign o_accLoadTr = out_q.acc_load_tr & ~i_stall;
    assign o_accClr    = out_q.acc_clr & ~i_stall;
    assign o_accEn     = out_q.acc_en & ~i_stall;
    assign o_wbEn      = out_q.wb_en & ~i_stall;
    assign o_vecIdx    = out_q.vec_idx;

endmodule

// File: tb/tb_gte_mac_sequencer.sv
// Self-checking bench for gte_mac_sequencer: directed latency/stall/reset cases plus
// randomized commands, all checked against a step-list model of the command schedule.
module tb_gte_mac_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, multi, stall;
    logic [1:0] mx, vec, cv;

    logic       o_busy, o_done, o_accLoadTr, o_accClr, o_accEn, o_wbEn;
    logic [1:0] o_mat, o_vcompo, o_vecIdx;
    logic [3:0] o_selLeft, o_selRight;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gte_mac_sequencer #(.NVEC_MULTI(3)) dut (
        .i_clk(clk), .i_nRst(rst_n), .i_start(start), .i_multi(multi),
        .i_mx(mx), .i_vec(vec), .i_cv(cv), .i_stall(stall),
        .o_busy(o_busy), .o_done(o_done), .o_mat(o_mat), .o_vcompo(o_vcompo),
        .o_selLeft(o_selLeft), .o_selRight(o_selRight), .o_accLoadTr(o_accLoadTr),
        .o_accClr(o_accClr), .o_accEn(o_accEn), .o_wbEn(o_wbEn), .o_vecIdx(o_vecIdx)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: on an accepted start, the whole command is laid out as a list of steps;
    // each unstalled cycle consumes one step, an empty list means idle.
    localparam logic [2:0] PH_TR = 3'd0, PH_C0 = 3'd1, PH_C1 = 3'd2, PH_C2 = 3'd3,
                           PH_WB = 3'd4, PH_DONE = 3'd5;
    typedef struct packed {
        logic [2:0] ph;
        logic [1:0] vidx;
    } step_t;

    step_t      q[$];
    logic       m_multi;
    logic [1:0] m_mx, m_vec, m_cv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else if (q.size() == 0) begin
            if (start) begin
                m_multi = multi; m_mx = mx; m_vec = vec; m_cv = cv;
                for (int v = 0; v < (multi ? 3 : 1); v++) begin
                    if (cv != 2'd3) q.push_back('{PH_TR, 2'(v)});
                    q.push_back('{PH_C0, 2'(v)});
                    q.push_back('{PH_C1, 2'(v)});
                    q.push_back('{PH_C2, 2'(v)});
                    q.push_back('{PH_WB, 2'(v)});
                end
                q.push_back('{PH_DONE, multi ? 2'd2 : 2'd0});
            end
        end else if (!stall) begin
            void'(q.pop_front());
        end
    end

    always @(negedge clk) begin : cmp
        logic [5:0]  ec, ac;
        logic [13:0] es, as_, mk;
        logic [3:0]  sl, sr;
        logic        is_c;
        step_t       st;
        ac  = {o_busy, o_done, o_accLoadTr, o_accClr, o_accEn, o_wbEn};
        as_ = {o_mat, o_vcompo, o_vecIdx, o_selLeft, o_selRight};
        if (q.size() == 0) begin
            check("ctrl_idle", 32'(ac), 32'd0);
        end else begin
            st   = q[0];
            is_c = (st.ph == PH_C0) || (st.ph == PH_C1) || (st.ph == PH_C2);
            ec   = {1'b1, (st.ph == PH_DONE) && !stall, (st.ph == PH_TR) && !stall,
                    (st.ph == PH_C0) && (m_cv == 2'd3) && !stall, is_c && !stall,
                    (st.ph == PH_WB) && !stall};
            check("ctrl", 32'(ac), 32'(ec));
            sl = (st.ph == PH_C1) ? 4'd1 : (st.ph == PH_C2) ? 4'd2 : 4'd0;
            sr = (st.ph == PH_TR) ? 4'd4 : 4'd0;
            es = {m_mx, m_multi ? st.vidx : m_vec, st.vidx, sl, sr};
            mk = {6'h3f, (is_c || st.ph == PH_TR) ? 8'hff : 8'h00};
            check("sel", 32'(as_ & mk), 32'(es & mk));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one command in the current cycle and measures start->o_done latency.
    task automatic run_cmd(input logic mul, input logic [1:0] m, input logic [1:0] v,
                           input logic [1:0] c, input int exp_lat,
                           input int st_at, input int st_len, input int dup_at);
        int s, k, lat, wb;
        start = 1'b1; multi = mul; mx = m; vec = v; cv = c;
        s = cyc; lat = -1; wb = 0;
        for (int j = 1; j <= 60; j++) begin
            tick();
            k = cyc - s;
            start = (k == dup_at);
            if (k == dup_at) begin
                mx = ~m; cv = ~c; multi = ~mul;
            end
            stall = (k >= st_at) && (k < st_at + st_len);
            @(negedge clk);
            if (o_wbEn) wb++;
            if (stall) begin
                check("stall_accEn", 32'(o_accEn), 32'd0);
                check("stall_selLeft", 32'(o_selLeft), 32'd1);
            end
            if (o_done) begin
                lat = k;
                break;
            end
        end
        check("done_latency", lat, exp_lat);
        check("wb_count", wb, mul ? 32'd3 : 32'd1);
        start = 1'b0; stall = 1'b0;
        tick();
        @(negedge clk);
        check("busy_after_done", 32'({o_busy, o_done}), 32'd0);
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; multi = 1'b0; stall = 1'b0;
        mx = '0; vec = '0; cv = '0;
        #1 rst_n = 1'b0;
        tick(); tick();
        @(negedge clk);
        check("reset_outputs", 32'({o_busy, o_done, o_mat, o_vcompo, o_selLeft, o_selRight,
                                    o_accLoadTr, o_accClr, o_accEn, o_wbEn, o_vecIdx}), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        run_cmd(1'b0, 2'd0, 2'd1, 2'd0, 6, 0, 0, -1);
        run_cmd(1'b0, 2'd2, 2'd3, 2'd3, 5, 0, 0, -1);
        run_cmd(1'b1, 2'd1, 2'd2, 2'd1, 16, 0, 0, -1);
        run_cmd(1'b1, 2'd3, 2'd0, 2'd3, 13, 0, 0, -1);
        run_cmd(1'b0, 2'd0, 2'd1, 2'd0, 9, 3, 3, -1);
        run_cmd(1'b0, 2'd1, 2'd2, 2'd0, 6, 0, 0, 2);
        for (int j = 0; j < 8; j++) begin
            tick();
            @(negedge clk);
            check("no_extra_done", 32'(o_done), 32'd0);
        end

        // Async reset in the middle of C1.
        tick();
        start = 1'b1; multi = 1'b0; mx = 2'd2; vec = 2'd1; cv = 2'd0;
        tick();
        start = 1'b0;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check("reset_mid_cmd", 32'({o_busy, o_done, o_mat, o_vcompo, o_selLeft, o_selRight,
                                    o_accLoadTr, o_accClr, o_accEn, o_wbEn, o_vecIdx}), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int j = 0; j < 10; j++) begin
            tick();
            @(negedge clk);
            check("post_reset_idle", 32'({o_busy, o_done, o_wbEn}), 32'd0);
        end

        for (int j = 0; j < 2500; j++) begin
            tick();
            start = ($urandom_range(0, 2) == 0);
            multi = 1'($urandom);
            mx    = 2'($urandom);
            vec   = 2'($urandom);
            cv    = 2'($urandom);
            stall = ($urandom_range(0, 3) == 0);
        end
        start = 1'b0; stall = 1'b0;
        for (int j = 0; j < 40; j++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
